// File: rtl/axi4_lite_master_if.sv
// axi4_lite_master_if: AXI4-lite bus between one initiator (master) and one responder (slave)
interface axi4_lite_if #(
   parameter int ADDRESS    = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDRESS-1:0]    M_AWADDR;
   logic                  M_AWVALID;
   logic                  M_AWREADY;
   logic [DATA_WIDTH-1:0] M_WDATA;
   logic [3:0]            M_WSTRB;
   logic                  M_WVALID;
   logic                  M_WREADY;
   logic [1:0]            M_BRESP;
   logic                  M_BVALID;
   logic                  M_BREADY;
   logic [ADDRESS-1:0]    M_ARADDR;
   logic                  M_ARVALID;
   logic                  M_ARREADY;
   logic [DATA_WIDTH-1:0] M_RDATA;
   logic [1:0]            M_RRESP;
   logic                  M_RVALID;
   logic                  M_RREADY;
   modport master (
      output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY, M_ARADDR, M_ARVALID, M_RREADY,
      input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
   );
   modport slave (
      input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY, M_ARADDR, M_ARVALID, M_RREADY,
      output M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID
   );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-lite initiator; define AXI_MASTER_TIMEOUT_EN to abort after TIMEOUT_CYCLES
module axi4_lite_master #(
   parameter int ADDRESS        = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDRESS-1:0]    cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic                  busy,
   axi4_lite_if.master           m
);
   typedef enum logic [2:0] {IDLE, WADDR_DATA, WRESP, RADDR, RDATA} state_t;
   state_t state, state_nxt;
   logic aw_done, w_done, awvalid, wvalid, write_q;
   logic [ADDRESS-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0] wstrb_q;
   logic accept, aw_hs, w_hs, b_hs, r_hs, done, timeout;
   assign cmd_ready   = state == IDLE;
   assign busy        = !cmd_ready;
   assign accept      = cmd_valid && cmd_ready;
   assign aw_hs       = awvalid && m.M_AWREADY;
   assign w_hs        = wvalid && m.M_WREADY;
   assign b_hs        = state == WRESP && m.M_BVALID;
   assign r_hs        = state == RDATA && m.M_RVALID;
   assign done        = b_hs || r_hs;
   assign m.M_AWADDR  = addr_q;
   assign m.M_ARADDR  = addr_q;
   assign m.M_WDATA   = wdata_q;
   assign m.M_WSTRB   = wstrb_q;
   assign m.M_AWVALID = awvalid;
   assign m.M_WVALID  = wvalid;
   assign m.M_BREADY  = state == WRESP;
   assign m.M_ARVALID = state == RADDR;
   assign m.M_RREADY  = state == RDATA;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       state_nxt = accept ? (cmd_write ? WADDR_DATA : RADDR) : IDLE;
         WADDR_DATA: state_nxt = (aw_done || aw_hs) && (w_done || w_hs) ? WRESP : WADDR_DATA;
         WRESP:      state_nxt = b_hs ? IDLE : WRESP;
         RADDR:      state_nxt = m.M_ARREADY ? RDATA : RADDR;
         RDATA:      state_nxt = r_hs ? IDLE : RDATA;
         default:    state_nxt = IDLE;
      endcase
      if (timeout) state_nxt = IDLE;
   end
   always_ff @(posedge ACLK)
      if (!ARESETN) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
      end else begin
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
         end
         // VALIDs are registered so they rise on the first WADDR_DATA cycle and fall right after their own handshake
         awvalid   <= (accept && cmd_write) || (awvalid && !m.M_AWREADY && !timeout);
         wvalid    <= (accept && cmd_write) || (wvalid && !m.M_WREADY && !timeout);
         aw_done   <= !accept && (aw_done || aw_hs);
         w_done    <= !accept && (w_done || w_hs);
         rsp_valid <= done || timeout;
         if (done || timeout) begin
            rsp_write <= write_q;
            rsp_rdata <= r_hs ? m.M_RDATA : '0;
            rsp_resp  <= timeout ? 2'b10 : (b_hs ? m.M_BRESP : m.M_RRESP);
         end
      end
   end
`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   // a completion landing on the last allowed cycle beats the abort
   assign timeout = state != IDLE && !done && cnt == CW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         cnt         <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         cnt <= accept ? '0 : cnt + ((state != IDLE) ? CW'(1) : CW'(0));
         if (done || timeout) rsp_timeout <= timeout;
      end
   end
`else
   assign timeout     = 1'b0;
   assign rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: scoreboard bench for axi4_lite_master against a configurable-latency slave model
module tb_axi4_lite_master;
   logic ACLK = 1'b0;
   logic ARESETN = 1'b0;
   always #5 ACLK = ~ACLK;
   logic cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic [3:0] cmd_wstrb = '0;
   logic cmd_ready, rsp_valid, rsp_write, rsp_timeout, busy;
   logic [31:0] rsp_rdata;
   logic [1:0] rsp_resp;
   axi4_lite_if bus ();
   axi4_lite_master #(.TIMEOUT_CYCLES(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy), .m(bus)
   );
   int checks = 0, errors = 0, cyc = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   typedef struct {
      logic        w;
      logic [31:0] rd;
      logic [1:0]  resp;
      logic        to;
      int          acc;
      int          lat;
   } exp_t;
   exp_t sb[$];
   // slave model configuration
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
   bit ar_never = 0, r_ovr = 0;
   logic [1:0] bresp_c = 2'b00, rresp_c = 2'b00;
   logic [31:0] rdata_c = '0;
   logic [31:0] mem [32];
   logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
   logic p_rst = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
   logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      bus.M_AWREADY = 0; bus.M_WREADY = 0; bus.M_BVALID = 0; bus.M_BRESP = 0;
      bus.M_ARREADY = 0; bus.M_RVALID = 0; bus.M_RDATA = 0; bus.M_RRESP = 0;
   end
   always @(negedge ACLK) begin
      if (bus.M_AWVALID) begin bus.M_AWREADY = aw_c == aw_dly; aw_c++; end
      else begin bus.M_AWREADY = 0; aw_c = 0; end
      if (bus.M_WVALID) begin bus.M_WREADY = w_c == w_dly; w_c++; end
      else begin bus.M_WREADY = 0; w_c = 0; end
      if (bus.M_ARVALID) begin bus.M_ARREADY = !ar_never && ar_c == ar_dly; ar_c++; end
      else begin bus.M_ARREADY = 0; ar_c = 0; end
      if (bus.M_BREADY) begin bus.M_BVALID = b_c == b_dly; bus.M_BRESP = bresp_c; b_c++; end
      else begin bus.M_BVALID = 0; b_c = 0; end
      if (bus.M_RREADY) begin
         bus.M_RVALID = r_c == r_dly;
         bus.M_RDATA  = r_ovr ? rdata_c : mem[s_araddr[6:2]];
         bus.M_RRESP  = rresp_c;
         r_c++;
      end else begin bus.M_RVALID = 0; r_c = 0; end
   end
   // handshakes as seen at the active edge
   always @(posedge ACLK) begin
      cyc++;
      p_rst = ARESETN;
      p_awv = bus.M_AWVALID; p_awr = bus.M_AWREADY; p_awaddr = bus.M_AWADDR;
      p_wv  = bus.M_WVALID;  p_wr  = bus.M_WREADY;  p_wdata  = bus.M_WDATA;
      p_arv = bus.M_ARVALID; p_arr = bus.M_ARREADY; p_araddr = bus.M_ARADDR;
      if (bus.M_AWVALID && bus.M_AWREADY) s_awaddr = bus.M_AWADDR;
      if (bus.M_WVALID && bus.M_WREADY) s_wdata = bus.M_WDATA;
      if (bus.M_ARVALID && bus.M_ARREADY) s_araddr = bus.M_ARADDR;
      if (bus.M_BVALID && bus.M_BREADY) mem[s_awaddr[6:2]] = s_wdata;
   end
   always @(negedge ACLK) if (p_rst) begin
      if (p_awv && !p_awr) begin check("aw_hold", bus.M_AWVALID, 1); check("aw_addr_stable", bus.M_AWADDR, p_awaddr); end
      if (p_wv && !p_wr) begin check("w_hold", bus.M_WVALID, 1); check("w_data_stable", bus.M_WDATA, p_wdata); end
      if (p_arv && !p_arr && !(rsp_valid && rsp_timeout)) begin
         check("ar_hold", bus.M_ARVALID, 1);
         check("ar_addr_stable", bus.M_ARADDR, p_araddr);
      end
   end
   always @(negedge ACLK) begin : mon
      exp_t e;
      if (rsp_valid) begin
         if (sb.size() == 0) check("rsp_unexpected", rsp_valid, 0);
         else begin
            e = sb.pop_front();
            check("rsp_write", rsp_write, e.w);
            check("rsp_rdata", rsp_rdata, e.rd);
            check("rsp_resp", rsp_resp, e.resp);
            check("rsp_timeout", rsp_timeout, e.to);
            if (e.lat > 0) check("rsp_latency", cyc - e.acc, e.lat);
         end
      end
   end
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] er, input logic [31:0] erd, input logic eto, input int lat);
      int n = 0;
      @(negedge ACLK);
      cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
      while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
      check("cmd_accept", cmd_ready, 1);
      if (cmd_ready) sb.push_back(exp_t'{w, w ? 32'h0 : erd, er, eto, cyc, lat});
      @(negedge ACLK);
      cmd_valid = 0;
   endtask
   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge ACLK); n++; end
      check("drain", sb.size(), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) @(negedge ACLK);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_awvalid", bus.M_AWVALID, 0);
      check("rst_wvalid", bus.M_WVALID, 0);
      check("rst_bready", bus.M_BREADY, 0);
      check("rst_arvalid", bus.M_ARVALID, 0);
      check("rst_rready", bus.M_RREADY, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      ARESETN = 1;
      issue(1, 32'h4, 32'hDEADBEEF, 2'b00, 0, 0, 3);
      check("wr_awvalid", bus.M_AWVALID, 1);
      check("wr_wvalid", bus.M_WVALID, 1);
      check("wr_awaddr", bus.M_AWADDR, 32'h4);
      check("wr_wdata", bus.M_WDATA, 32'hDEADBEEF);
      check("wr_wstrb", bus.M_WSTRB, 4'hF);
      check("wr_busy", busy, 1);
      @(negedge ACLK);
      check("wr_bready", bus.M_BREADY, 1);
      issue(0, 32'h4, 0, 2'b00, 32'hDEADBEEF, 0, 3);
      check("rd_arvalid", bus.M_ARVALID, 1);
      check("rd_araddr", bus.M_ARADDR, 32'h4);
      aw_dly = 3;
      issue(1, 32'h8, 32'hCAFEF00D, 2'b00, 0, 0, 6);
      check("slow_aw_awvalid1", bus.M_AWVALID, 1);
      check("slow_aw_wvalid1", bus.M_WVALID, 1);
      for (int i = 2; i <= 4; i++) begin
         @(negedge ACLK);
         check("slow_aw_wvalid_low", bus.M_WVALID, 0);
         check("slow_aw_awvalid_held", bus.M_AWVALID, 1);
         check("slow_aw_no_bready", bus.M_BREADY, 0);
      end
      @(negedge ACLK);
      check("slow_aw_awvalid_low", bus.M_AWVALID, 0);
      check("slow_aw_bready", bus.M_BREADY, 1);
      aw_dly = 0;
      issue(0, 32'h8, 0, 2'b00, 32'hCAFEF00D, 0, 3);
      drain();
      r_dly = 5; rresp_c = 2'b10; r_ovr = 1; rdata_c = 32'h12345678;
      issue(0, 32'hC, 0, 2'b10, 32'h12345678, 0, 8);
      drain();
      repeat (2) @(negedge ACLK);
      check("hold_rdata", rsp_rdata, 32'h12345678);
      check("hold_resp", rsp_resp, 2'b10);
      r_dly = 0; rresp_c = 2'b00; r_ovr = 0;
      b_dly = 2; bresp_c = 2'b11;
      issue(1, 32'h14, 32'h0BADF00D, 2'b11, 0, 0, 5);
      drain();
      bresp_c = 2'b00; b_dly = 100;
      issue(1, 32'h10, 32'h55AA55AA, 2'b00, 0, 0, 0);
      @(negedge ACLK);
      check("rstmid_bready_before", bus.M_BREADY, 1);
      ARESETN = 0;
      @(negedge ACLK);
      check("rstmid_bready", bus.M_BREADY, 0);
      check("rstmid_cmd_ready", cmd_ready, 1);
      check("rstmid_busy", busy, 0);
      check("rstmid_rsp_valid", rsp_valid, 0);
      ARESETN = 1;
      b_dly = 0;
      void'(sb.pop_back());
      repeat (3) @(negedge ACLK);
      issue(0, 32'h4, 0, 2'b00, 32'hDEADBEEF, 0, 3);
      issue(0, 32'h10, 0, 2'b00, 32'h0, 0, 3);
      drain();
`ifdef AXI_MASTER_TIMEOUT_EN
      ar_never = 1;
      issue(0, 32'h20, 0, 2'b10, 32'h0, 1, 17);
      repeat (15) @(negedge ACLK);
      check("to_arvalid_last", bus.M_ARVALID, 1);
      @(negedge ACLK);
      check("to_arvalid_drop", bus.M_ARVALID, 0);
      check("to_cmd_ready", cmd_ready, 1);
      ar_never = 0;
      drain();
      issue(0, 32'h8, 0, 2'b00, 32'hCAFEF00D, 0, 3);
`endif
      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
